// File: rtl/vproc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vproc_pkg
// Description : Shared types for the vector processor divide-result collector.
//               Provides the collector state encoding and the default-width
//               register-file write request record.
// Revision    : 1.0 - initial release
// ============================================================================
package vproc_pkg;

   // Default datapath widths used by the shared write-request record
   localparam int unsigned VPROC_VREG_W  = 128;
   localparam int unsigned VPROC_VADDR_W = 5;

   // Collector state encoding
   typedef enum logic [1:0] {
      IDLE    = 2'd0,   // no partial register held
      COLLECT = 2'd1,   // at least one part accepted
      WRITE   = 2'd2    // write request pending on the register-file port
   } collect_state_e;

   // Register-file write request at the default widths
   typedef struct packed {
      logic [VPROC_VADDR_W-1:0]  addr;
      logic [VPROC_VREG_W-1:0]   data;
      logic [VPROC_VREG_W/8-1:0] be;
   } vreg_wr_req_t;

endpackage
`default_nettype wire

// File: rtl/vproc_div_res_collect.sv
`default_nettype none
// ============================================================================
// Module      : vproc_div_res_collect
// Description : Consumer end of the divide unit result pipe. Packs
//               DIV_OP_W-wide result beats (with byte masks) into full
//               VREG_W-wide byte-enabled register writes, absorbs write-port
//               backpressure and drops writes whose byte enables are all zero.
// Revision    : 1.0 - initial release
//
// Configuration macro:
//   VPROC_DIV_COLLECT_BYPASS_EN - when defined, a beat may be accepted in the
//   same cycle as the write handshake and starts the next register, giving
//   one beat per cycle sustained. Undefined: one idle bubble after each write.
//
// Ports:
//   clk_i            in   clock
//   async_rst_i      in   asynchronous reset, active-high
//   pipe_in_valid_i  in   result beat valid
//   pipe_in_ready_o  out  result beat accepted when valid & ready
//   pipe_in_first_i  in   beat is part 0 of a register
//   pipe_in_last_i   in   beat is the final part of a register
//   pipe_in_vaddr_i  in   destination register (sampled on the first beat)
//   pipe_in_res_i    in   result data
//   pipe_in_mask_i   in   byte write mask for this beat
//   vreg_wr_valid_o  out  register write request
//   vreg_wr_ready_i  in   write port accepts the request
//   vreg_wr_addr_o   out  write address
//   vreg_wr_data_o   out  write data
//   vreg_wr_be_o     out  byte enables
//   done_o           out  one-cycle pulse per completed register
//   proto_err_o      out  one-cycle pulse on first/last protocol violation
// ============================================================================
module vproc_div_res_collect
   import vproc_pkg::*;
#(
   parameter int unsigned DIV_OP_W = 64,
   parameter int unsigned VREG_W   = 128,
   parameter int unsigned VADDR_W  = 5
) (
   input  logic                  clk_i,
   input  logic                  async_rst_i,
   input  logic                  pipe_in_valid_i,
   output logic                  pipe_in_ready_o,
   input  logic                  pipe_in_first_i,
   input  logic                  pipe_in_last_i,
   input  logic [VADDR_W-1:0]    pipe_in_vaddr_i,
   input  logic [DIV_OP_W-1:0]   pipe_in_res_i,
   input  logic [DIV_OP_W/8-1:0] pipe_in_mask_i,
   output logic                  vreg_wr_valid_o,
   input  logic                  vreg_wr_ready_i,
   output logic [VADDR_W-1:0]    vreg_wr_addr_o,
   output logic [VREG_W-1:0]     vreg_wr_data_o,
   output logic [VREG_W/8-1:0]   vreg_wr_be_o,
   output logic                  done_o,
   output logic                  proto_err_o
);

   localparam int unsigned PARTS  = VREG_W / DIV_OP_W;
   localparam int unsigned CNT_W  = (PARTS > 1) ? $clog2(PARTS) : 1;
   localparam int unsigned MASK_W = DIV_OP_W / 8;
   localparam logic [CNT_W-1:0] LAST_PART = CNT_W'(PARTS - 1);

   // Write request at this instance's widths
   typedef struct packed {
      logic [VADDR_W-1:0]  addr;
      logic [VREG_W-1:0]   data;
      logic [VREG_W/8-1:0] be;
   } req_t;

   collect_state_e   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   req_t             req_q, req_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             in_ready;
   logic             accept;
   logic             wr_hs;

   // Scratch values inside the next-state process
   logic             from_idle;
   logic             complete;
   logic [CNT_W-1:0] cnt_base;
   req_t             req_base;

   assign wr_hs = (state_q == WRITE) & vreg_wr_ready_i;

`ifdef VPROC_DIV_COLLECT_BYPASS_EN
   assign in_ready = (state_q != WRITE) | vreg_wr_ready_i;
`else
   assign in_ready = (state_q != WRITE);
`endif

   assign accept = pipe_in_valid_i & in_ready;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      from_idle = (state_q == IDLE);
      complete  = 1'b0;
      cnt_base  = cnt_q;
      req_base  = req_q;

      // Write handshake retires the register. Without the bypass no beat can
      // be accepted in this cycle; with it, a concurrent beat sees a clean
      // IDLE context.
      if (wr_hs) begin
         done_d    = 1'b1;
         state_d   = IDLE;
         cnt_d     = '0;
         req_d     = '0;
         from_idle = 1'b1;
      end

      if (accept) begin
         // Start of a register: either nothing is in flight, or a first beat
         // arrives mid-register and discards the partial one.
         if (from_idle || pipe_in_first_i) begin
            cnt_base      = '0;
            req_base      = '0;
            req_base.addr = pipe_in_vaddr_i;
         end

         if (from_idle && !pipe_in_first_i) begin
            err_d = 1'b1;
         end else if (!from_idle && pipe_in_first_i) begin
            err_d = 1'b1;
         end

         for (int p = 0; p < int'(PARTS); p++) begin
            if (cnt_base == CNT_W'(p)) begin
               req_base.data[p*DIV_OP_W +: DIV_OP_W] = pipe_in_res_i;
               req_base.be[p*MASK_W +: MASK_W]       = pipe_in_mask_i;
            end
         end

         complete = pipe_in_last_i | (cnt_base == LAST_PART);

         if (complete) begin
            if (|req_base.be) begin
               state_d = WRITE;
               cnt_d   = cnt_base;
               req_d   = req_base;
            end else begin
               // Every element masked: retire without touching the port
               done_d  = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
               req_d   = '0;
            end
         end else begin
            state_d = COLLECT;
            cnt_d   = cnt_base + CNT_W'(1);
            req_d   = req_base;
         end
      end
   end

   always_ff @(posedge clk_i or posedge async_rst_i) begin
      if (async_rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign pipe_in_ready_o = in_ready;
   assign vreg_wr_valid_o = (state_q == WRITE);
   assign vreg_wr_addr_o  = req_q.addr;
   assign vreg_wr_data_o  = req_q.data;
   assign vreg_wr_be_o    = req_q.be;
   assign done_o          = done_q;
   assign proto_err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vproc_div_res_collect.sv
`default_nettype none
// ============================================================================
// Module      : tb_vproc_div_res_collect
// Description : Directed self-checking bench for vproc_div_res_collect at
//               VREG_W=128, DIV_OP_W=64, VADDR_W=5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vproc_div_res_collect;

`ifdef VPROC_DIV_COLLECT_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic         clk_i = 1'b0;
   logic         async_rst_i;
   logic         pipe_in_valid_i;
   logic         pipe_in_ready_o;
   logic         pipe_in_first_i;
   logic         pipe_in_last_i;
   logic [4:0]   pipe_in_vaddr_i;
   logic [63:0]  pipe_in_res_i;
   logic [7:0]   pipe_in_mask_i;
   logic         vreg_wr_valid_o;
   logic         vreg_wr_ready_i;
   logic [4:0]   vreg_wr_addr_o;
   logic [127:0] vreg_wr_data_o;
   logic [15:0]  vreg_wr_be_o;
   logic         done_o;
   logic         proto_err_o;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   int wr_count = 0;

   localparam logic [63:0] A = 64'h1111_2222_3333_4444;
   localparam logic [63:0] B = 64'hAAAA_BBBB_CCCC_DDDD;
   localparam logic [63:0] C = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] D = 64'hDEAD_BEEF_0000_0001;
   localparam logic [63:0] E = 64'hEEEE_EEEE_EEEE_EEEE;
   localparam logic [63:0] F = 64'hFFFF_0000_FFFF_0000;
   localparam logic [63:0] G = 64'h1234_5678_9ABC_DEF0;
   localparam logic [63:0] H = 64'h0000_0000_0000_00AB;

   vproc_div_res_collect #(
      .DIV_OP_W (64),
      .VREG_W   (128),
      .VADDR_W  (5)
   ) dut (
      .clk_i           (clk_i),
      .async_rst_i     (async_rst_i),
      .pipe_in_valid_i (pipe_in_valid_i),
      .pipe_in_ready_o (pipe_in_ready_o),
      .pipe_in_first_i (pipe_in_first_i),
      .pipe_in_last_i  (pipe_in_last_i),
      .pipe_in_vaddr_i (pipe_in_vaddr_i),
      .pipe_in_res_i   (pipe_in_res_i),
      .pipe_in_mask_i  (pipe_in_mask_i),
      .vreg_wr_valid_o (vreg_wr_valid_o),
      .vreg_wr_ready_i (vreg_wr_ready_i),
      .vreg_wr_addr_o  (vreg_wr_addr_o),
      .vreg_wr_data_o  (vreg_wr_data_o),
      .vreg_wr_be_o    (vreg_wr_be_o),
      .done_o          (done_o),
      .proto_err_o     (proto_err_o)
   );

   always #5 clk_i = ~clk_i;

   // Count completed write handshakes on the register-file port
   always @(posedge clk_i) begin
      if (!async_rst_i && vreg_wr_valid_o && vreg_wr_ready_i) begin
         wr_count <= wr_count + 1;
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic first, input logic last, input logic [4:0] va,
                       input logic [63:0] res, input logic [7:0] mask);
      pipe_in_valid_i = 1'b1;
      pipe_in_first_i = first;
      pipe_in_last_i  = last;
      pipe_in_vaddr_i = va;
      pipe_in_res_i   = res;
      pipe_in_mask_i  = mask;
   endtask

   task automatic no_beat();
      pipe_in_valid_i = 1'b0;
      pipe_in_first_i = 1'b0;
      pipe_in_last_i  = 1'b0;
      pipe_in_vaddr_i = '0;
      pipe_in_res_i   = '0;
      pipe_in_mask_i  = '0;
   endtask

   initial begin
      async_rst_i     = 1'b1;
      vreg_wr_ready_i = 1'b0;
      no_beat();
      step();
      step();

      // ---------------- reset state ----------------
      chk("rst_valid", 128'(vreg_wr_valid_o), 128'd0);
      chk("rst_addr",  128'(vreg_wr_addr_o),  128'd0);
      chk("rst_data",  vreg_wr_data_o,        128'd0);
      chk("rst_be",    128'(vreg_wr_be_o),    128'd0);
      chk("rst_done",  128'(done_o),          128'd0);
      chk("rst_err",   128'(proto_err_o),     128'd0);
      chk("rst_ready", 128'(pipe_in_ready_o), 128'd1);
      async_rst_i = 1'b0;
      step();

      // ---------------- full register ----------------
      vreg_wr_ready_i = 1'b1;
      beat(1'b1, 1'b0, 5'd3, A, 8'hFF);
      step();
      chk("full_ready_collect", 128'(pipe_in_ready_o), 128'd1);
      chk("full_valid_collect", 128'(vreg_wr_valid_o), 128'd0);
      beat(1'b0, 1'b1, 5'd0, B, 8'hFF);
      step();
      no_beat();
      chk("full_valid", 128'(vreg_wr_valid_o), 128'd1);
      chk("full_addr",  128'(vreg_wr_addr_o),  128'd3);
      chk("full_data",  vreg_wr_data_o,        {B, A});
      chk("full_be",    128'(vreg_wr_be_o),    128'hFFFF);
      chk("full_ready_write", 128'(pipe_in_ready_o), 128'(BYP));
      chk("full_done_early", 128'(done_o), 128'd0);
      step();
      chk("full_done",  128'(done_o),          128'd1);
      chk("full_valid_after", 128'(vreg_wr_valid_o), 128'd0);
      chk("full_wrcnt", 128'(wr_count),        128'd1);
      step();
      chk("full_done_pulse", 128'(done_o),     128'd0);

      // ---------------- early last ----------------
      beat(1'b1, 1'b1, 5'd7, C, 8'h0F);
      step();
      no_beat();
      chk("early_valid", 128'(vreg_wr_valid_o), 128'd1);
      chk("early_addr",  128'(vreg_wr_addr_o),  128'd7);
      chk("early_be",    128'(vreg_wr_be_o),    128'h000F);
      chk("early_data",  vreg_wr_data_o,        {64'h0, C});
      step();
      chk("early_done",  128'(done_o),          128'd1);

      // ---------------- backpressure ----------------
      vreg_wr_ready_i = 1'b0;
      beat(1'b1, 1'b1, 5'd9, D, 8'hFF);
      step();
      no_beat();
      for (int c = 1; c <= 3; c++) begin
         chk($sformatf("bp_valid_c%0d", c), 128'(vreg_wr_valid_o), 128'd1);
         chk($sformatf("bp_ready_c%0d", c), 128'(pipe_in_ready_o), 128'd0);
         chk($sformatf("bp_addr_c%0d",  c), 128'(vreg_wr_addr_o),  128'd9);
         chk($sformatf("bp_data_c%0d",  c), vreg_wr_data_o,        {64'h0, D});
         chk($sformatf("bp_be_c%0d",    c), 128'(vreg_wr_be_o),    128'h00FF);
         chk($sformatf("bp_done_c%0d",  c), 128'(done_o),          128'd0);
         step();
      end
      chk("bp_valid_c4", 128'(vreg_wr_valid_o), 128'd1);
      vreg_wr_ready_i = 1'b1;
      step();
      chk("bp_valid_after", 128'(vreg_wr_valid_o), 128'd0);
      chk("bp_done",  128'(done_o),   128'd1);
      chk("bp_wrcnt", 128'(wr_count), 128'd3);

      // ---------------- fully masked ----------------
      beat(1'b1, 1'b0, 5'd10, 64'h5555_5555_5555_5555, 8'h00);
      step();
      beat(1'b0, 1'b1, 5'd0, 64'h6666_6666_6666_6666, 8'h00);
      step();
      no_beat();
      chk("mask_valid", 128'(vreg_wr_valid_o), 128'd0);
      chk("mask_done",  128'(done_o),          128'd1);
      chk("mask_be",    128'(vreg_wr_be_o),    128'd0);
      step();
      chk("mask_done_pulse", 128'(done_o),     128'd0);
      chk("mask_valid2", 128'(vreg_wr_valid_o), 128'd0);
      chk("mask_wrcnt",  128'(wr_count),        128'd3);

      // ---------------- first in COLLECT ----------------
      beat(1'b1, 1'b0, 5'd4, E, 8'hFF);
      step();
      beat(1'b1, 1'b0, 5'd5, F, 8'hFF);
      step();
      chk("err_restart_err",   128'(proto_err_o),     128'd1);
      chk("err_restart_done",  128'(done_o),          128'd0);
      chk("err_restart_valid", 128'(vreg_wr_valid_o), 128'd0);
      beat(1'b0, 1'b1, 5'd0, G, 8'hF0);
      step();
      no_beat();
      chk("err_restart_err_clr", 128'(proto_err_o), 128'd0);
      chk("err_restart_wvalid",  128'(vreg_wr_valid_o), 128'd1);
      chk("err_restart_addr",    128'(vreg_wr_addr_o),  128'd5);
      chk("err_restart_data",    vreg_wr_data_o,        {G, F});
      chk("err_restart_be",      128'(vreg_wr_be_o),    128'hF0FF);
      step();
      chk("err_restart_wrcnt",   128'(wr_count), 128'd4);
      chk("err_restart_wdone",   128'(done_o),   128'd1);

      // ---------------- no first in IDLE ----------------
      beat(1'b0, 1'b1, 5'd6, H, 8'h01);
      step();
      no_beat();
      chk("err_idle_err",   128'(proto_err_o),     128'd1);
      chk("err_idle_valid", 128'(vreg_wr_valid_o), 128'd1);
      chk("err_idle_addr",  128'(vreg_wr_addr_o),  128'd6);
      chk("err_idle_be",    128'(vreg_wr_be_o),    128'h0001);
      chk("err_idle_data",  vreg_wr_data_o,        {64'h0, H});
      step();
      chk("err_idle_done",  128'(done_o),   128'd1);
      chk("err_idle_wrcnt", 128'(wr_count), 128'd5);

      // ---------------- reset between parts ----------------
      beat(1'b1, 1'b0, 5'd2, A, 8'hFF);
      step();
      no_beat();
      async_rst_i = 1'b1;
      #1;
      chk("mrst_valid", 128'(vreg_wr_valid_o), 128'd0);
      chk("mrst_addr",  128'(vreg_wr_addr_o),  128'd0);
      chk("mrst_data",  vreg_wr_data_o,        128'd0);
      chk("mrst_be",    128'(vreg_wr_be_o),    128'd0);
      chk("mrst_done",  128'(done_o),          128'd0);
      chk("mrst_err",   128'(proto_err_o),     128'd0);
      step();
      async_rst_i = 1'b0;
      step();
      step();
      step();
      chk("mrst_valid_after", 128'(vreg_wr_valid_o), 128'd0);
      chk("mrst_done_after",  128'(done_o),          128'd0);
      chk("mrst_wrcnt",       128'(wr_count),        128'd5);

`ifdef VPROC_DIV_COLLECT_BYPASS_EN
      // ---------------- back-to-back with bypass ----------------
      vreg_wr_ready_i = 1'b1;
      beat(1'b1, 1'b0, 5'd11, A, 8'hFF);
      chk("byp_ready0", 128'(pipe_in_ready_o), 128'd1);
      step();
      beat(1'b0, 1'b1, 5'd0, B, 8'hFF);
      chk("byp_ready1", 128'(pipe_in_ready_o), 128'd1);
      step();
      chk("byp_w1_valid", 128'(vreg_wr_valid_o), 128'd1);
      chk("byp_w1_addr",  128'(vreg_wr_addr_o),  128'd11);
      chk("byp_w1_data",  vreg_wr_data_o,        {B, A});
      beat(1'b1, 1'b0, 5'd12, C, 8'hFF);
      chk("byp_ready2", 128'(pipe_in_ready_o), 128'd1);
      step();
      chk("byp_done1", 128'(done_o), 128'd1);
      beat(1'b0, 1'b1, 5'd0, D, 8'hFF);
      chk("byp_ready3", 128'(pipe_in_ready_o), 128'd1);
      step();
      no_beat();
      chk("byp_w2_valid", 128'(vreg_wr_valid_o), 128'd1);
      chk("byp_w2_addr",  128'(vreg_wr_addr_o),  128'd12);
      chk("byp_w2_data",  vreg_wr_data_o,        {D, C});
      step();
      chk("byp_wrcnt", 128'(wr_count), 128'd7);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
